// File: rtl/airlock_pkg.sv
// Shared types and seven-segment constants for the airlock countdown display.
package airlock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_FP,
        RUN_EV
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_O     = 7'b1000000;

    // Character codes: 0..9 are digits, 10..15 render blank, letters above
    typedef logic [4:0] char_t;

    localparam char_t CH_P     = 5'd16;
    localparam char_t CH_E     = 5'd17;
    localparam char_t CH_C     = 5'd18;
    localparam char_t CH_O     = 5'd19;
    localparam char_t CH_DASH  = 5'd20;
    localparam char_t CH_BLANK = 5'd31;

    // Numeric value to character code; values above 9 land on blank codes
    function automatic char_t digit_char(input logic [3:0] value);
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational character code to active-low seven-segment pattern.
module seg7_encode
    import airlock_pkg::*;
(
    input  char_t      ch,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for one character
    always_comb begin
        seg = SEG_BLANK;
        case (ch)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            CH_P:    seg = SEG_P;
            CH_E:    seg = SEG_E;
            CH_C:    seg = SEG_C;
            CH_O:    seg = SEG_O;
            CH_DASH: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/airlock_countdown_display.sv
// Seconds countdown for airlock fill/pressurize and evacuate cycles, with
// door-open abort and a six-digit status display.
module airlock_countdown_display
    import airlock_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned FP_SECONDS = 7,
    parameter int unsigned EV_SECONDS = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start_fp,
    input  logic       start_ev,
    input  logic       inner_closed,
    input  logic       outer_closed,
    input  logic       pressurized,
    input  logic       evacuated,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       done_fp,
    output logic       done_ev,
    output logic       aborted,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] FP_LOAD = 4'(FP_SECONDS);
    localparam logic [3:0] EV_LOAD = 4'(EV_SECONDS);

    state_t        state_q, state_d;
    logic [3:0]    remaining_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic          start_fp_q, start_ev_q;
    logic          rise_fp, rise_ev, tick, door_open;
    logic          done_fp_d, done_ev_d, aborted_d;
    char_t         chars [6];
    logic [6:0]    segs  [6];

    assign rise_fp   = start_fp & ~start_fp_q;
    assign rise_ev   = start_ev & ~start_ev_q;
    assign tick      = (prescaler_q == TICK_LAST);
    assign door_open = ~inner_closed | ~outer_closed;
    assign busy      = (state_q != IDLE);

    // State, countdown, prescaler, edge history and completion pulses
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            remaining   <= '0;
            prescaler_q <= '0;
            start_fp_q  <= 1'b0;
            start_ev_q  <= 1'b0;
            done_fp     <= 1'b0;
            done_ev     <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining   <= remaining_d;
            prescaler_q <= prescaler_d;
            start_fp_q  <= start_fp;
            start_ev_q  <= start_ev;
            done_fp     <= done_fp_d;
            done_ev     <= done_ev_d;
            aborted     <= aborted_d;
        end
    end

    // Next-state: start acceptance, per-second ticking, abort over final tick
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining;
        prescaler_d = prescaler_q;
        done_fp_d   = 1'b0;
        done_ev_d   = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            IDLE: begin
                prescaler_d = '0;
                if (rise_fp && !rise_ev) begin
                    remaining_d = FP_LOAD;
                    state_d     = RUN_FP;
                end else if (rise_ev && !rise_fp) begin
                    remaining_d = EV_LOAD;
                    state_d     = RUN_EV;
                end
            end
            RUN_FP, RUN_EV: begin
                if (door_open) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    prescaler_d = '0;
                    aborted_d   = 1'b1;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (remaining > 4'd1) begin
                        remaining_d = remaining - 4'd1;
                    end else begin
                        remaining_d = '0;
                        state_d     = IDLE;
                        done_fp_d   = (state_q == RUN_FP);
                        done_ev_d   = (state_q == RUN_EV);
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                prescaler_d = '0;
            end
        endcase
    end

    // Character selection for each display digit from current state and inputs
    always_comb begin
        chars[0] = (state_q == IDLE) ? CH_BLANK : digit_char(remaining);
        chars[1] = CH_BLANK;
        chars[2] = outer_closed ? CH_C : CH_O;
        chars[3] = inner_closed ? CH_C : CH_O;
        chars[4] = CH_DASH;
        if (pressurized && !evacuated)
            chars[4] = CH_P;
        else if (evacuated && !pressurized)
            chars[4] = CH_E;
        case (state_q)
            RUN_FP:  chars[5] = CH_P;
            RUN_EV:  chars[5] = CH_E;
            default: chars[5] = CH_DASH;
        endcase
    end

    for (genvar i = 0; i < 6; i++) begin : g_enc
        seg7_encode u_enc (
            .ch  (chars[i]),
            .seg (segs[i])
        );
    end

    // Registered display outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_DASH;
            HEX3 <= SEG_DASH;
            HEX4 <= SEG_DASH;
            HEX5 <= SEG_DASH;
        end else begin
            HEX0 <= segs[0];
            HEX1 <= segs[1];
            HEX2 <= segs[2];
            HEX3 <= segs[3];
            HEX4 <= segs[4];
            HEX5 <= segs[5];
        end
    end

endmodule

// File: tb/tb_airlock_countdown_display.sv
// Self-checking bench for airlock_countdown_display: directed plan steps
// followed by random stimulus, compared against a cycle-count reference model.
module tb_airlock_countdown_display;

    localparam int TD = 4;
    localparam int FP = 3;
    localparam int EV = 2;

    localparam logic [6:0] S_BLANK = 7'h7F;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_P     = 7'b0001100;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_C     = 7'b1000110;
    localparam logic [6:0] S_O     = 7'b1000000;

    logic [6:0] digit_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    logic       Clock = 1'b0;
    logic       Reset, start_fp, start_ev, inner_closed, outer_closed;
    logic       pressurized, evacuated;
    logic       busy, done_fp, done_ev, aborted;
    logic [3:0] remaining;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 fill/pressurize, 2 evacuate;
    // cycles_left counts clock cycles until completion.
    int         m_mode = 0;
    int         m_cycles_left = 0;
    bit         m_prev_fp = 0, m_prev_ev = 0;
    bit         e_done_fp = 0, e_done_ev = 0, e_aborted = 0;
    logic [6:0] e_hex [6];

    airlock_countdown_display #(
        .TICK_DIV   (TD),
        .FP_SECONDS (FP),
        .EV_SECONDS (EV)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .start_fp     (start_fp),
        .start_ev     (start_ev),
        .inner_closed (inner_closed),
        .outer_closed (outer_closed),
        .pressurized  (pressurized),
        .evacuated    (evacuated),
        .busy         (busy),
        .remaining    (remaining),
        .done_fp      (done_fp),
        .done_ev      (done_ev),
        .aborted      (aborted),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3),
        .HEX4         (HEX4),
        .HEX5         (HEX5)
    );

    always #5 Clock = ~Clock;

    function automatic int model_remaining();
        return (m_cycles_left + TD - 1) / TD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",      32'(busy),      32'(m_mode != 0));
        chk("remaining", 32'(remaining), 32'(model_remaining()));
        chk("done_fp",   32'(done_fp),   32'(e_done_fp));
        chk("done_ev",   32'(done_ev),   32'(e_done_ev));
        chk("aborted",   32'(aborted),   32'(e_aborted));
        chk("hex0",      32'(HEX0),      32'(e_hex[0]));
        chk("hex1",      32'(HEX1),      32'(e_hex[1]));
        chk("hex2",      32'(HEX2),      32'(e_hex[2]));
        chk("hex3",      32'(HEX3),      32'(e_hex[3]));
        chk("hex4",      32'(HEX4),      32'(e_hex[4]));
        chk("hex5",      32'(HEX5),      32'(e_hex[5]));
    endtask

    // Advance the model over one clock edge, apply the edge, then compare
    task automatic step();
        bit rf, re;
        int rem;
        rem = model_remaining();
        e_done_fp = 0;
        e_done_ev = 0;
        e_aborted = 0;
        if (!Reset) begin
            m_mode = 0;
            m_cycles_left = 0;
            m_prev_fp = 0;
            m_prev_ev = 0;
            e_hex = '{S_BLANK, S_BLANK, S_DASH, S_DASH, S_DASH, S_DASH};
        end else begin
            e_hex[0] = (m_mode == 0) ? S_BLANK : digit_tab[rem];
            e_hex[1] = S_BLANK;
            e_hex[2] = outer_closed ? S_C : S_O;
            e_hex[3] = inner_closed ? S_C : S_O;
            e_hex[4] = (pressurized && !evacuated) ? S_P :
                       (evacuated && !pressurized) ? S_E : S_DASH;
            e_hex[5] = (m_mode == 1) ? S_P : (m_mode == 2) ? S_E : S_DASH;
            rf = start_fp && !m_prev_fp;
            re = start_ev && !m_prev_ev;
            if (m_mode == 0) begin
                if (rf && !re) begin
                    m_mode = 1;
                    m_cycles_left = FP * TD;
                end else if (re && !rf) begin
                    m_mode = 2;
                    m_cycles_left = EV * TD;
                end
            end else if (!inner_closed || !outer_closed) begin
                m_mode = 0;
                m_cycles_left = 0;
                e_aborted = 1;
            end else begin
                m_cycles_left--;
                if (m_cycles_left == 0) begin
                    e_done_fp = (m_mode == 1);
                    e_done_ev = (m_mode == 2);
                    m_mode = 0;
                end
            end
            m_prev_fp = start_fp;
            m_prev_ev = start_ev;
        end
        @(posedge Clock);
        #1;
        check_all();
    endtask

    initial begin
        Reset = 1'b0;
        start_fp = 1'b0;
        start_ev = 1'b0;
        inner_closed = 1'b1;
        outer_closed = 1'b1;
        pressurized = 1'b0;
        evacuated = 1'b0;

        // 1: reset
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hex0", 32'(HEX0), 32'(S_BLANK));
        chk("rst_hex5", 32'(HEX5), 32'(S_DASH));
        Reset = 1'b1;
        step();
        chk("rst_rem", 32'(remaining), 32'd0);

        // 2: fill/pressurize countdown, start held high throughout
        start_fp = 1'b1;
        step();
        chk("fp_busy", 32'(busy), 32'd1);
        chk("fp_rem_start", 32'(remaining), 32'd3);
        step();
        chk("fp_hex5", 32'(HEX5), 32'(S_P));
        repeat (10) step();
        step();
        chk("fp_done", 32'(done_fp), 32'd1);
        chk("fp_done_idle", 32'(busy), 32'd0);
        step();
        chk("fp_done_width", 32'(done_fp), 32'd0);
        chk("fp_no_retrigger", 32'(busy), 32'd0);
        start_fp = 1'b0;
        step();

        // 3: evacuate aborted by the outer port opening
        start_ev = 1'b1;
        step();
        start_ev = 1'b0;
        step();
        outer_closed = 1'b0;
        step();
        chk("ev_aborted", 32'(aborted), 32'd1);
        chk("ev_abort_rem", 32'(remaining), 32'd0);
        step();
        chk("ev_abort_width", 32'(aborted), 32'd0);
        chk("ev_hex2_open", 32'(HEX2), 32'(S_O));
        outer_closed = 1'b1;
        step();

        // 4: simultaneous starts ignored; start_ev during RUN_FP ignored
        start_fp = 1'b1;
        start_ev = 1'b1;
        step();
        chk("both_idle", 32'(busy), 32'd0);
        start_fp = 1'b0;
        start_ev = 1'b0;
        step();
        start_fp = 1'b1;
        step();
        start_ev = 1'b1;
        step();
        chk("fp_ignore_ev", 32'(HEX5), 32'(S_P));
        start_ev = 1'b0;
        repeat (12) step();
        start_fp = 1'b0;
        step();

        // 5: reset during RUN_EV with one second left
        start_ev = 1'b1;
        step();
        start_ev = 1'b0;
        repeat (5) step();
        chk("ev_last_sec", 32'(remaining), 32'd1);
        Reset = 1'b0;
        step();
        chk("rst_mid_hex0", 32'(HEX0), 32'(S_BLANK));
        Reset = 1'b1;
        repeat (4) step();

        // 6: chamber state display
        pressurized = 1'b1; evacuated = 1'b0; step();
        chk("hex4_p", 32'(HEX4), 32'(S_P));
        pressurized = 1'b0; evacuated = 1'b1; step();
        chk("hex4_e", 32'(HEX4), 32'(S_E));
        pressurized = 1'b1; evacuated = 1'b1; step();
        chk("hex4_both", 32'(HEX4), 32'(S_DASH));

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            Reset        = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) start_fp = ~start_fp;
            if ($urandom_range(0, 9) == 0) start_ev = ~start_ev;
            inner_closed = ($urandom_range(0, 59) != 0);
            outer_closed = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) begin
                pressurized = 1'($urandom_range(0, 1));
                evacuated   = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/airlock_countdown_display.md
Name: airlock_countdown_display

Overview:
- Downstream consumer of the airlock interlock top level.
- Takes the countdown-start levels from the fill/pressurize and evacuate controllers, plus the door and chamber state bits.
- Runs a visible seconds countdown and drives HEX0..HEX5 with the remaining time, active operation, chamber state and door states.
- Aborts a running countdown if a door opens. Reports completion or abort with one-cycle pulses.

Parameters:
- TICK_DIV, 50000000: Clock cycles per displayed second. Must be ≥2; set small in simulation.
- FP_SECONDS, 7: Fill/pressurize countdown length in seconds, range 1..9.
- EV_SECONDS, 5: Evacuate countdown length in seconds, range 1..9.

Ports:
- Clock  in  1  system clock (CLOCK_50)
- Reset  in  1  synchronous, active-low reset
- start_fp  in  1  fill/pressurize countdown request; level, edge-detected internally
- start_ev  in  1  evacuate countdown request; level, edge-detected internally
- inner_closed  in  1  1 = inner port closed
- outer_closed  in  1  1 = outer port closed
- pressurized  in  1  chamber pressurized state
- evacuated  in  1  chamber evacuated state
- busy  out  1  countdown running
- remaining  out  4  seconds left; 0 when idle
- done_fp  out  1  one-cycle pulse, FP countdown completed
- done_ev  out  1  one-cycle pulse, EV countdown completed
- aborted  out  1  one-cycle pulse, countdown cancelled by an open door
- HEX0..HEX5  out  7 each  active-low segments, bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset (Reset==0 at a Clock edge):
  - state=IDLE, remaining=0, prescaler=0, start edge registers=0.
  - busy=0 and all pulse outputs=0.
  - HEX0=HEX1=blank (7'h7F); HEX2..HEX5='-' (7'b0111111).
  - Reset mid-countdown abandons it with no done or aborted pulse.
- Edge detect: rise_x = start_x & ~start_x_q. start_x_q is registered every cycle.
- FSM states:
  - IDLE:
    - rise_fp only: remaining<=FP_SECONDS, prescaler<=0, go RUN_FP.
    - rise_ev only: remaining<=EV_SECONDS, prescaler<=0, go RUN_EV.
    - Both rise in the same cycle: both ignored, stay IDLE.
    - The cycle after the rising level is seen, busy=1.
  - RUN_FP / RUN_EV:
    - Prescaler counts 0..TICK_DIV-1. tick = (prescaler==TICK_DIV-1), after which the prescaler wraps to 0.
    - On tick with remaining>1: remaining decrements.
    - On tick with remaining==1: remaining<=0, go IDLE, and done_fp or done_ev pulses for exactly 1 cycle.
    - Total duration from acceptance to done = N*TICK_DIV cycles (N = FP_SECONDS or EV_SECONDS).
    - New start edges while running are ignored; they are not queued.
- Abort: in RUN_*, if inner_closed==0 or outer_closed==0, then next edge: go IDLE, remaining=0, aborted pulses 1 cycle, no done pulse. Abort has priority over a coincident final tick.
- busy = (state != IDLE).
- Display outputs are registered, updated every cycle from current state and inputs (1-cycle latency):
  - HEX0: digit of remaining in RUN_*, blank in IDLE.
  - HEX1: always blank.
  - HEX2: outer port, 'C' (1000110) if closed, 'O' (1000000) if open.
  - HEX3: inner port, same 'C'/'O' encoding.
  - HEX4: chamber. 'P' (0001100) if pressurized & ~evacuated; 'E' (0000110) if evacuated & ~pressurized; '-' otherwise, including both set.
  - HEX5: operation. 'P' in RUN_FP, 'E' in RUN_EV, '-' in IDLE.
- Digit codes 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Values above 9 display blank.

Decomposition:
- Shared package airlock_pkg:
  - state enum {IDLE, RUN_FP, RUN_EV}
  - 7-seg constants SEG_BLANK, SEG_DASH, SEG_P, SEG_E, SEG_C, SEG_O
- Sub-module seg7_encode: combinational, 5-bit char code (digits 0–9 plus letters) -> 7-bit active-low segments. Instantiated six times.

Test Plan (TICK_DIV=4, FP_SECONDS=3, EV_SECONDS=2, doors closed):
1. Reset low 2 cycles, then high -> busy=0, remaining=0, HEX0=7F, HEX5=0111111, all pulses 0.
2. start_fp 0->1 held high -> busy=1 next cycle, HEX5=0001100. remaining goes 3,2,1 at 4-cycle spacing. done_fp high exactly 1 cycle, 12 cycles after acceptance. remaining=0 and busy=0 at the same time as done_fp. No retrigger while start_fp stays high.
3. start_ev pulse, then outer_closed=0 two cycles later -> aborted 1-cycle pulse, remaining=0, no done_ev, HEX2=1000110 changes to 1000000.
4. start_fp and start_ev rise in the same cycle -> stays IDLE, busy=0. start_ev pulse during a running RUN_FP is ignored and remaining is unchanged.
5. Reset low mid RUN_EV with remaining=1 -> IDLE next edge, no done_ev, HEX0=7F.
6. pressurized/evacuated = 10, 01, 11 -> HEX4 = 0001100, 0000110, 0111111, each one cycle after the input changes.
